change_dispenser_module: RTL and testbench



---
 rtl/change_dispenser_module.sv | 118 +++++++++++
 tb/tb_change_dispenser_module.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser_module.sv
// Change dispenser: pays out owed change one coin at a time through a
// request/acknowledge handshake with the coin hopper, then pulses the brewer.
// A hopper that never acknowledges a request parks the block in a sticky
// fault state that only reset clears.
module change_dispenser_module #(
    parameter int COIN_W      = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COIN_W-1:0] change,
    input  logic              enable,
    input  logic              hopper_ready,
    input  logic              hopper_ack,
    output logic              coin_req,
    output logic [COIN_W-1:0] coins_left,
    output logic              busy,
    output logic              brew_start,
    output logic              done,
    output logic              fault
);

    // The counter only ever has to reach ACK_TIMEOUT-1.
    localparam int               TMR_W    = $clog2(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_REQ,
        S_GAP,
        S_BREW,
        S_DONE,
        S_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [COIN_W-1:0] coins_left_q, coins_left_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              enable_q, enable_d;
    logic              accept;

    // Next-state, coin bookkeeping and the request timeout counter.
    always_comb begin
        state_d      = state_q;
        coins_left_d = coins_left_q;
        timer_d      = '0;
        enable_d     = enable;
        accept       = enable & ~enable_q & (state_q == S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    coins_left_d = change;
                    state_d      = (change == '0) ? S_BREW : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (hopper_ready) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // An acknowledge in the same cycle as the timeout still counts.
                if (hopper_ack) begin
                    coins_left_d = coins_left_q - COIN_W'(1);
                    state_d      = S_GAP;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_GAP: begin
                state_d = (coins_left_q == '0) ? S_BREW : S_WAIT_RDY;
            end
            S_BREW: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and enable history; enable history resets high so a
    // level held through reset is not mistaken for a fresh purchase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            coins_left_q <= '0;
            timer_q      <= '0;
            enable_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            coins_left_q <= coins_left_d;
            timer_q      <= timer_d;
            enable_q     <= enable_d;
        end
    end

    // Moore decode of the actuator and status outputs.
    always_comb begin
        coin_req   = (state_q == S_REQ);
        busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
        brew_start = (state_q == S_BREW);
        done       = (state_q == S_DONE);
        fault      = (state_q == S_FAULT);
        coins_left = coins_left_q;
    end

endmodule

// File: tb/tb_change_dispenser_module.sv
// Bench for change_dispenser_module: a table of purchases run against a
// behavioural hopper, with a scoreboard of expected completions, plus
// hand-written fault, reset-abort and enable-toggle sequences.
module tb_change_dispenser_module;

    localparam int COIN_W      = 4;
    localparam int ACK_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [COIN_W-1:0] change = '0;
    logic              enable = 1'b1;
    logic              hopper_ready = 1'b0;
    logic              hopper_ack = 1'b0;
    logic              coin_req;
    logic [COIN_W-1:0] coins_left;
    logic              busy;
    logic              brew_start;
    logic              done;
    logic              fault;

    change_dispenser_module #(
        .COIN_W      (COIN_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .change       (change),
        .enable       (enable),
        .hopper_ready (hopper_ready),
        .hopper_ack   (hopper_ack),
        .coin_req     (coin_req),
        .coins_left   (coins_left),
        .busy         (busy),
        .brew_start   (brew_start),
        .done         (done),
        .fault        (fault)
    );

    // Free-running clock and a rising-edge counter used to time latencies.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int change;
        int ready_delay;
        int ack_delay;
        int exp_pulses;
        int exp_latency;
    } vec_t;

    typedef struct {
        int n;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    int checks = 0;
    int passes = 0;

    int cfg_ready_delay = 0;
    int cfg_ack_delay   = 0;
    int cfg_block_pulse = 0;
    int cur_change      = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drop enable for a cycle, then raise it with the new change value.
    task automatic applyStimulus(input int ch, input int exp_n, input int exp_lat, input bit push);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        change     = COIN_W'(ch);
        enable     = 1'b1;
        cur_change = ch;
        if (push) sb.push_back('{exp_n, exp_lat, cyc});
    endtask

    task automatic waitIdle(input string name);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        checkOutput(name, sb.size(), 0);
        @(negedge clk);
    endtask

    // Hopper model and output monitor: drives ready/ack, checks every coin
    // and every completion against the scoreboard.
    initial begin
        int  req_cycles = 0;
        int  pulse_cnt  = 0;
        int  low_cnt    = 0;
        int  exp_left   = 0;
        int  brew_cyc   = -10;
        bit  acked      = 0;
        bit  prev_req   = 0;
        bit  prev_busy  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cycles   = 0;
                pulse_cnt    = 0;
                low_cnt      = 0;
                exp_left     = 0;
                acked        = 0;
                prev_req     = 0;
                prev_busy    = 0;
                hopper_ack   = 1'b0;
                hopper_ready = 1'b0;
            end else begin
                if (busy && !prev_busy) exp_left = cur_change;
                if (brew_start) brew_cyc = cyc;
                if (prev_req && !coin_req) begin
                    pulse_cnt++;
                    if (acked) exp_left--;
                    checkOutput("coins_left_after_coin", coins_left, exp_left);
                    checkOutput("coin_req_width", req_cycles,
                                (pulse_cnt == cfg_block_pulse) ? ACK_TIMEOUT : cfg_ack_delay + 1);
                    req_cycles = 0;
                    acked      = 0;
                end
                if (coin_req) begin
                    req_cycles++;
                    low_cnt = 0;
                end else if (busy) begin
                    low_cnt++;
                end else begin
                    low_cnt = 0;
                end
                hopper_ready = (low_cnt > cfg_ready_delay);
                hopper_ack   = coin_req && (req_cycles == cfg_ack_delay + 1)
                               && (pulse_cnt + 1 != cfg_block_pulse);
                if (hopper_ack) acked = 1;
                if (done) begin
                    checkOutput("done_has_pending", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput("coin_pulses", pulse_cnt, e.n);
                        if (e.lat >= 0) checkOutput("done_latency", cyc - e.acc_cyc, e.lat);
                        checkOutput("brew_before_done", brew_cyc, cyc - 1);
                        checkOutput("coins_left_at_done", coins_left, 0);
                    end
                    pulse_cnt = 0;
                end
                prev_req  = coin_req;
                prev_busy = busy;
            end
        end
    end

    // Main sequence.
    initial begin
        vecs[0] = '{3,  0, 0, 3,  11};
        vecs[1] = '{0,  0, 0, 0,  2};
        vecs[2] = '{1,  0, 0, 1,  5};
        vecs[3] = '{4,  0, 2, 4,  22};
        vecs[4] = '{15, 5, 4, 15, -1};
        vecs[5] = '{15, 0, 0, 15, 47};

        // Reset with enable held high.
        repeat (2) @(negedge clk);
        checkOutput("rst_coin_req", coin_req, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_brew_start", brew_start, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_coins_left", coins_left, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("held_enable_no_accept", busy, 0);
        end

        // Table of purchases.
        for (int i = 0; i < 6; i++) begin
            cfg_ready_delay = vecs[i].ready_delay;
            cfg_ack_delay   = vecs[i].ack_delay;
            cfg_block_pulse = 0;
            applyStimulus(vecs[i].change, vecs[i].exp_pulses, vecs[i].exp_latency, 1'b1);
            waitIdle("table_completion_timeout");
        end

        // Enable toggles during a transaction must not start a second one.
        cfg_ready_delay = 0;
        cfg_ack_delay   = 0;
        applyStimulus(3, 3, 11, 1'b1);
        @(negedge clk); enable = 1'b0;
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        @(negedge clk); enable = 1'b1;
        waitIdle("toggle_completion_timeout");
        repeat (10) @(negedge clk);
        checkOutput("toggle_no_second_txn", busy, 0);

        // Hopper stalls on the second coin.
        cfg_block_pulse = 2;
        applyStimulus(2, 0, 0, 1'b0);
        for (int i = 0; i < 200 && !fault; i++) @(negedge clk);
        checkOutput("fault_reached", fault, 1);
        checkOutput("fault_coin_req", coin_req, 0);
        checkOutput("fault_busy", busy, 0);
        checkOutput("fault_coins_left", coins_left, 1);
        @(negedge clk); enable = 1'b0;
        @(negedge clk); enable = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("fault_sticky", fault, 1);
        checkOutput("fault_ignores_enable", busy, 0);
        checkOutput("fault_coins_frozen", coins_left, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        checkOutput("fault_cleared_by_rst", fault, 0);
        checkOutput("fault_rst_coins_left", coins_left, 0);
        @(negedge clk); rst = 1'b0;
        cfg_block_pulse = 0;

        // Reset while requesting the second of three coins.
        cfg_ack_delay = 3;
        applyStimulus(3, 0, 0, 1'b0);
        for (int i = 0; i < 200 && !(coin_req && coins_left == 2); i++) @(negedge clk);
        checkOutput("mid_req_reached", int'(coin_req && coins_left == 2), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_coin_req", coin_req, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_coins_left", coins_left, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_brew_start", brew_start, 0);
        checkOutput("abort_fault", fault, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_stays_idle", busy, 0);

        // Recovery after the abort.
        cfg_ack_delay = 0;
        applyStimulus(2, 2, 8, 1'b1);
        waitIdle("recovery_completion_timeout");

        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Global bound so a stuck design cannot hang the run.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
